serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, over WIDTH cycles.
// Optional two's-complement overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             borrow,
  output logic             ovf
`else
  output logic             borrow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             accept;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_bit, b_bit, d_bit, bout_bit;
  logic             last_bit;

  assign a_bit    = a_sh_reg[0];
  assign b_bit    = b_sh_reg[0];
  assign d_bit    = a_bit ^ b_bit ^ borrow_reg;
  assign bout_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);
  assign last_bit = (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        // Start held across DONE chains straight into the next operation.
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      borrow_reg <= 1'b0;
      cnt_reg    <= CW'(WIDTH - 1);
    end else if (state_reg == SHIFT) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      // Result bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
      diff_reg   <= {d_bit, diff_reg[WIDTH-1:1]};
      borrow_reg <= bout_bit;
      if (!last_bit) cnt_reg <= cnt_reg - CW'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  // On the last bit the shift-register LSBs hold the operand sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == SHIFT && last_bit) begin
      ovf_reg <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy   = (state_reg == SHIFT);
  assign done   = (state_reg == DONE);
  assign diff   = diff_reg;
  assign borrow = borrow_reg;

endmodule
